pc_ir_unit: RTL and testbench
=============================

# pc_ir_unit

Multicycle datapath front end that sits directly downstream of the multicycle control unit. It consumes that unit's PC, instruction-register and memory-access controls, and holds the architectural PC, the instruction register (IR), the memory data register (MDR) and the ALUOut register. It drives a unified instruction/data memory through a ready-based handshake. It returns a `stall` signal that freezes the control FSM while a memory access is outstanding, and a sticky bus error if the memory never answers.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `TIMEOUT`, 16, maximum wait cycles for `mem_ready` before bus error; legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low reset (`reset==0` at a rising edge resets).
- `PCWrite`, `Branch`, `IRWrite`, `IorD`, `MemRead`, `MemWrite` input 1 each: controls from the control unit.
- `PCSrc` input 2: next-PC select. 00 = `alu_result`, 01 = ALUOut, 10 = jump target, 11 = hold.
- `alu_result` input 32: live ALU output.
- `alu_zero` input 1: ALU zero flag.
- `wdata` input 32: store data (register rt).
- `mem_addr` output 32: memory address.
- `mem_wdata` output 32: memory write data.
- `mem_rd`, `mem_wr` output 1 each: memory request strobes.
- `mem_rdata` input 32: memory read data.
- `mem_ready` input 1: access completes this cycle.
- `pc` output 32: current PC.
- `instr` output 32: IR contents.
- `opcode`, `funct` output 6 each: IR[31:26] and IR[5:0].
- `mdr` output 32: MDR contents.
- `alu_out` output 32: ALUOut register.
- `stall` output 1: control FSM must hold its state this cycle.
- `bus_error` output 1: sticky timeout flag.

## Operation
- **Request.**
  - `req = MemRead | MemWrite`. If both are high, the read wins and no write is issued.
  - `mem_rd = MemRead & ~bus_error`.
  - `mem_wr = MemWrite & ~MemRead & ~bus_error`.
  - `mem_addr = IorD ? alu_out : pc`.
  - `mem_wdata = wdata`.
  - All request outputs are combinational from the controls, which stay stable while stalled.
- **Completion.**
  - `done = req & mem_ready & ~bus_error`.
  - `stall = (req & ~done) | bus_error`.
- **FSM states.**
  - IDLE:
    - `req & mem_ready` completes in the same cycle and stays in IDLE.
    - `req & ~mem_ready` goes to WAIT with `wcnt=1`.
  - WAIT:
    - `done` returns to IDLE.
    - `~req` (protocol violation) returns to IDLE with no side effects.
    - Otherwise `wcnt` increments. Reaching `wcnt==TIMEOUT` without ready goes to ERROR.
  - ERROR: `bus_error=1` and `stall=1`. The block leaves ERROR only on reset.
- **IR.** Loads `mem_rdata` when `IRWrite & MemRead & done`.
- **MDR.** Loads `mem_rdata` when `MemRead & done`.
- **ALUOut.** Loads `alu_result` every cycle with `stall==0`.
- **PC.**
  - `pc_en = ~stall & (PCWrite | (Branch & alu_zero))`.
  - Next PC per `PCSrc`. The jump target is `{pc[31:28], instr[25:0], 2'b00}`.
  - A FETCH-cycle PC+4 update happens exactly once, in the completing cycle.
- **Arithmetic.** No arithmetic is done in this block. `pc[1:0]` is not forced, and misaligned values pass through unchanged.

## Timing
- **Reset values:**
  - `pc=RESET_PC`.
  - `instr`, `mdr`, `alu_out` = 0.
  - FSM in IDLE, `wcnt=0`, `bus_error=0`.
  - `stall=0` while `req=0`.
- **Latency.**
  - Zero-wait memory: the access completes in 1 cycle and the IR/MDR/PC updates are visible on the next edge.
  - N-wait memory: `stall` is high for N cycles and the update follows the edge where `mem_ready=1`.
- **Boundaries.**
  - `mem_ready` arriving on the cycle where `wcnt==TIMEOUT` counts as success; the error is raised only after that cycle.
  - `mem_ready` while `req=0` is ignored.
  - Reset low mid-WAIT aborts the access; no register is written that cycle.
  - A Branch with `alu_zero=0` performs no PC write.
  - `PCWrite` and `Branch` together OR into `pc_en`.

## Structure
- **Shared package** holds:
  - `PCSRC_*` encodings: `PCSRC_ALU=2'b00`, `PCSRC_ALUOUT=2'b01`, `PCSRC_JUMP=2'b10`.
  - The IDLE/WAIT/ERROR state enum.
  - The `RESET_PC` default.
  - These are shared with the control unit and top level.
- **Sub-module `mem_handshake`** contains the FSM, the `wcnt` counter, `stall`, `bus_error` and the strobe gating. The PC/IR/MDR/ALUOut registers stay in `pc_ir_unit`.

## Test plan
- **Reset fetch, zero-wait.**
  - Stimulus: release reset; MemRead=IRWrite=PCWrite=1, PCSrc=00, alu_result=4, `mem_ready=1`, `mem_rdata=32'h8C01_0004`.
  - Required: `mem_addr=0`, `stall=0`, next edge `instr=32'h8C01_0004`, `pc=4`.
- **Wait states.**
  - Stimulus: the same fetch with `mem_ready` low for 3 cycles.
  - Required: `stall=1` for 3 cycles, `pc` held at 0; PC and IR update once only, on the ready edge.
- **Timeout.**
  - Stimulus: TIMEOUT=4, MemRead held, `mem_ready` never asserted.
  - Required: `bus_error=1` after 4 wait cycles, `mem_rd=0`, `stall` stuck at 1 until `reset=0`.
- **Branch.**
  - Stimulus: `alu_out=32'h40`, Branch=1, PCSrc=01.
  - Required: with `alu_zero=1`, `pc=32'h40`; with `alu_zero=0`, `pc` unchanged.
- **Jump.**
  - Stimulus: `pc=32'h1000_0008`, `instr=32'h0800_0010`, PCWrite=1, PCSrc=10.
  - Required: `pc=32'h1000_0040`.
- **Load/store.**
  - Stimulus: IorD=1, `alu_out=32'h200`.
  - Required for MemWrite with `wdata=32'hDEAD_BEEF`: `mem_wr=1`, `mem_addr=32'h200`, `mem_wdata=32'hDEAD_BEEF`.
  - Required for MemRead with `mem_rdata=32'h1234`: `mdr=32'h1234` and `instr` unchanged.

Source files
------------

// File: rtl/pc_ir_unit_pkg.sv
// Shared encodings for the multicycle front end: next-PC selects,
// memory handshake states and the default reset PC.
package pc_ir_unit_pkg;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_ERROR = 2'b10
  } hs_state_t;

endpackage

// File: rtl/pc_ir_unit_mem_handshake.sv
// Ready-based memory handshake: strobe gating, wait counter, stall and a
// sticky bus error once the memory fails to answer within TIMEOUT waits.
module mem_handshake
  import pc_ir_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_mem_read,
  input  logic i_mem_write,
  input  logic i_mem_ready,
  output logic o_mem_rd,
  output logic o_mem_wr,
  output logic o_done,
  output logic o_stall,
  output logic o_bus_error
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  hs_state_t  r_state;
  logic [7:0] r_wcnt;
  logic       w_req;

  assign w_req       = i_mem_read | i_mem_write;
  assign o_bus_error = (r_state == ST_ERROR);
  assign o_mem_rd    = i_mem_read & ~o_bus_error;
  assign o_mem_wr    = i_mem_write & ~i_mem_read & ~o_bus_error;
  assign o_done      = w_req & i_mem_ready & ~o_bus_error;
  assign o_stall     = (w_req & ~o_done) | o_bus_error;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_wcnt  <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req && !i_mem_ready) begin
            r_state <= ST_WAIT;
            r_wcnt  <= 8'd1;
          end
        end
        ST_WAIT: begin
          // Ready on the wcnt==TIMEOUT cycle still succeeds; the error follows it.
          if (!w_req || i_mem_ready) begin
            r_state <= ST_IDLE;
            r_wcnt  <= 8'd0;
          end else if (r_wcnt == LP_TIMEOUT) begin
            r_state <= ST_ERROR;
          end else begin
            r_wcnt <= r_wcnt + 8'd1;
          end
        end
        ST_ERROR: r_state <= ST_ERROR;
        default: begin
          r_state <= ST_IDLE;
          r_wcnt  <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_ir_unit.sv
// Multicycle datapath front end: PC, IR, MDR and ALUOut registers driving a
// unified memory through the mem_handshake stall/timeout logic.
module pc_ir_unit
  import pc_ir_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic        IRWrite,
  input  logic        IorD,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic [31:0] wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] mdr,
  output logic [31:0] alu_out,
  output logic        stall,
  output logic        bus_error
);

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_mdr;
  logic [31:0] r_alu_out;
  logic [31:0] w_pc_next;
  logic        w_pc_en;
  logic        w_done;

  mem_handshake #(
    .TIMEOUT(TIMEOUT)
  ) u_hs (
    .clk         (clk),
    .reset       (reset),
    .i_mem_read  (MemRead),
    .i_mem_write (MemWrite),
    .i_mem_ready (mem_ready),
    .o_mem_rd    (mem_rd),
    .o_mem_wr    (mem_wr),
    .o_done      (w_done),
    .o_stall     (stall),
    .o_bus_error (bus_error)
  );

  assign mem_addr  = IorD ? r_alu_out : r_pc;
  assign mem_wdata = wdata;
  assign w_pc_en   = ~stall & (PCWrite | (Branch & alu_zero));

  always_comb begin
    w_pc_next = r_pc;
    case (PCSrc)
      PCSRC_ALU:    w_pc_next = alu_result;
      PCSRC_ALUOUT: w_pc_next = r_alu_out;
      PCSRC_JUMP:   w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
      default:      w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_ir      <= 32'd0;
      r_mdr     <= 32'd0;
      r_alu_out <= 32'd0;
    end else begin
      if (w_pc_en)                      r_pc      <= w_pc_next;
      if (IRWrite && MemRead && w_done) r_ir      <= mem_rdata;
      if (MemRead && w_done)            r_mdr     <= mem_rdata;
      if (!stall)                       r_alu_out <= alu_result;
    end
  end

  assign pc      = r_pc;
  assign instr   = r_ir;
  assign opcode  = r_ir[31:26];
  assign funct   = r_ir[5:0];
  assign mdr     = r_mdr;
  assign alu_out = r_alu_out;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed bench for pc_ir_unit with TIMEOUT=4 and hand-computed expectations.
module tb_pc_ir_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, Branch, IRWrite, IorD, MemRead, MemWrite;
  logic [1:0]  PCSrc;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] wdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] pc, instr, mdr, alu_out;
  logic [5:0]  opcode, funct;
  logic        stall, bus_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_ir_unit #(.RESET_PC(32'h0), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .Branch(Branch), .IRWrite(IRWrite),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .PCSrc(PCSrc),
    .alu_result(alu_result), .alu_zero(alu_zero), .wdata(wdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc), .instr(instr),
    .opcode(opcode), .funct(funct), .mdr(mdr), .alu_out(alu_out),
    .stall(stall), .bus_error(bus_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    PCWrite = 0; Branch = 0; IRWrite = 0; IorD = 0; MemRead = 0; MemWrite = 0;
    PCSrc = 2'b11; alu_zero = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    idle_ctrl();
    alu_result = 32'h0; wdata = 32'h0; mem_rdata = 32'h0;
    reset = 0;
    tick(); tick();
    reset = 1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp %h", instr, 32'h0); end
    checks++; if (mdr !== 32'h0) begin errors++; $display("FAIL reset_mdr got %h exp %h", mdr, 32'h0); end
    checks++; if (alu_out !== 32'h0) begin errors++; $display("FAIL reset_alu_out got %h exp %h", alu_out, 32'h0); end
    checks++; if ({stall, bus_error, mem_rd, mem_wr} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {stall, bus_error, mem_rd, mem_wr}); end
    $display("test_reset: pc=%h stall=%b", pc, stall);
  endtask

  task automatic test_fetch_zero_wait();
    do_reset();
    MemRead = 1; IRWrite = 1; PCWrite = 1; PCSrc = 2'b00; alu_result = 32'h4;
    mem_ready = 1; mem_rdata = 32'h8C01_0004;
    #1;
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL fetch_addr got %h exp %h", mem_addr, 32'h0); end
    checks++; if ({stall, mem_rd} !== 2'b01) begin errors++; $display("FAIL fetch_stall_rd got %b exp 01", {stall, mem_rd}); end
    tick(); idle_ctrl(); #1;
    checks++; if (instr !== 32'h8C01_0004) begin errors++; $display("FAIL fetch_instr got %h exp %h", instr, 32'h8C01_0004); end
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL fetch_pc got %h exp %h", pc, 32'h4); end
    checks++; if ({opcode, funct} !== {6'h23, 6'h04}) begin errors++; $display("FAIL fetch_fields got %h/%h exp 23/04", opcode, funct); end
    checks++; if (mdr !== 32'h8C01_0004) begin errors++; $display("FAIL fetch_mdr got %h exp %h", mdr, 32'h8C01_0004); end
    $display("test_fetch_zero_wait: pc=%h instr=%h", pc, instr);
  endtask

  task automatic test_wait_states();
    do_reset();
    MemRead = 1; IRWrite = 1; PCWrite = 1; PCSrc = 2'b00; alu_result = 32'h4;
    mem_ready = 0; mem_rdata = 32'h0123_4567;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({stall, pc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL wait_stall_%0d got stall=%b pc=%h exp stall=1 pc=0", i, stall, pc); end
      tick();
    end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL wait_instr_held got %h exp %h", instr, 32'h0); end
    mem_ready = 1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wait_ready_stall got %b exp 0", stall); end
    tick();
    checks++; if ({pc, instr} !== {32'h4, 32'h0123_4567}) begin errors++; $display("FAIL wait_update got pc=%h instr=%h exp 4/01234567", pc, instr); end
    alu_result = 32'h8; mem_ready = 0; tick();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL wait_once got %h exp %h", pc, 32'h4); end
    idle_ctrl();
    $display("test_wait_states: pc=%h instr=%h", pc, instr);
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    MemRead = 1; mem_ready = 0; mem_rdata = 32'hCAFE_0001;
    for (int i = 0; i < 4; i++) tick();
    mem_ready = 1; #1;
    checks++; if ({stall, bus_error} !== 2'b00) begin errors++; $display("FAIL edge_ready got %b exp 00", {stall, bus_error}); end
    tick(); idle_ctrl(); #1;
    checks++; if ({bus_error, mdr} !== {1'b0, 32'hCAFE_0001}) begin errors++; $display("FAIL edge_done got err=%b mdr=%h exp 0/cafe0001", bus_error, mdr); end
    $display("test_timeout_boundary: mdr=%h", mdr);
  endtask

  task automatic test_timeout();
    do_reset();
    MemRead = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", bus_error); end
    tick();
    checks++; if ({bus_error, mem_rd, stall} !== 3'b101) begin errors++; $display("FAIL timeout_err got %b exp 101", {bus_error, mem_rd, stall}); end
    mem_ready = 1; tick(); MemRead = 0; #1;
    checks++; if ({bus_error, stall, mem_rd} !== 3'b110) begin errors++; $display("FAIL timeout_sticky got %b exp 110", {bus_error, stall, mem_rd}); end
    reset = 0; tick(); reset = 1; mem_ready = 0; #1;
    checks++; if ({bus_error, stall} !== 2'b00) begin errors++; $display("FAIL timeout_clear got %b exp 00", {bus_error, stall}); end
    $display("test_timeout: cleared by reset");
  endtask

  task automatic test_branch();
    do_reset();
    alu_result = 32'h40; tick();
    Branch = 1; PCSrc = 2'b01; alu_zero = 0; tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL branch_nt got %h exp %h", pc, 32'h0); end
    alu_zero = 1; tick();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL branch_t got %h exp %h", pc, 32'h40); end
    PCWrite = 1; alu_zero = 0; PCSrc = 2'b00; alu_result = 32'h80; tick();
    checks++; if (pc !== 32'h80) begin errors++; $display("FAIL branch_or got %h exp %h", pc, 32'h80); end
    idle_ctrl();
    $display("test_branch: pc=%h", pc);
  endtask

  task automatic test_jump();
    do_reset();
    PCWrite = 1; PCSrc = 2'b00; alu_result = 32'h1000_0008; tick();
    PCWrite = 0; MemRead = 1; IRWrite = 1; mem_ready = 1; mem_rdata = 32'h0800_0010; #1;
    checks++; if (mem_addr !== 32'h1000_0008) begin errors++; $display("FAIL jump_fetch_addr got %h exp %h", mem_addr, 32'h1000_0008); end
    tick(); idle_ctrl();
    PCWrite = 1; PCSrc = 2'b10; tick();
    checks++; if (pc !== 32'h1000_0040) begin errors++; $display("FAIL jump_pc got %h exp %h", pc, 32'h1000_0040); end
    PCSrc = 2'b11; tick();
    checks++; if (pc !== 32'h1000_0040) begin errors++; $display("FAIL jump_hold got %h exp %h", pc, 32'h1000_0040); end
    idle_ctrl();
    $display("test_jump: pc=%h", pc);
  endtask

  task automatic test_load_store();
    do_reset();
    alu_result = 32'h200; tick();
    IorD = 1; MemWrite = 1; wdata = 32'hDEAD_BEEF; mem_ready = 1; #1;
    checks++; if ({mem_wr, mem_rd} !== 2'b10) begin errors++; $display("FAIL store_strobes got %b exp 10", {mem_wr, mem_rd}); end
    checks++; if ({mem_addr, mem_wdata} !== {32'h200, 32'hDEAD_BEEF}) begin errors++; $display("FAIL store_bus got %h/%h exp 200/deadbeef", mem_addr, mem_wdata); end
    MemRead = 1; #1;
    checks++; if ({mem_wr, mem_rd} !== 2'b01) begin errors++; $display("FAIL read_wins got %b exp 01", {mem_wr, mem_rd}); end
    MemWrite = 0; mem_rdata = 32'h1234; tick(); idle_ctrl(); #1;
    checks++; if ({mdr, instr} !== {32'h1234, 32'h0}) begin errors++; $display("FAIL load_mdr got %h/%h exp 1234/0", mdr, instr); end
    mem_ready = 1; mem_rdata = 32'hFFFF_FFFF; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL noreq_stall got %b exp 0", stall); end
    tick();
    checks++; if (mdr !== 32'h1234) begin errors++; $display("FAIL noreq_mdr got %h exp %h", mdr, 32'h1234); end
    idle_ctrl();
    $display("test_load_store: mdr=%h", mdr);
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    MemRead = 1; IRWrite = 1; PCWrite = 1; PCSrc = 2'b00; alu_result = 32'h4;
    mem_ready = 0; mem_rdata = 32'h5555_AAAA;
    tick(); tick();
    reset = 0; mem_ready = 1; tick();
    checks++; if ({pc, instr, mdr} !== {32'h0, 32'h0, 32'h0}) begin errors++; $display("FAIL abort_regs got %h/%h/%h exp 0/0/0", pc, instr, mdr); end
    reset = 1; idle_ctrl(); #1;
    checks++; if ({stall, bus_error} !== 2'b00) begin errors++; $display("FAIL abort_flags got %b exp 00", {stall, bus_error}); end
    $display("test_reset_mid_wait: pc=%h", pc);
  endtask

  initial begin
    reset = 0;
    idle_ctrl();
    alu_result = 0; wdata = 0; mem_rdata = 0;
    test_reset();
    test_fetch_zero_wait();
    test_wait_states();
    test_timeout_boundary();
    test_timeout();
    test_branch();
    test_jump();
    test_load_store();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
